// File: rtl/id_operand_fwd_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : id_operand_fwd_stage_pkg
//  Description : Shared constants for the decode-stage operand unit: default
//                datapath widths and the forwarding-bus layout. Forwarding
//                bus fields are flat vectors; source i occupies
//                dest[i*RA_W +: RA_W], data[i*XLEN +: XLEN], data_ok[i].
//  Revision    : 1.0 - initial release
// ============================================================================
package id_operand_fwd_stage_pkg;

    localparam int unsigned c_XLEN_DEF      = 32;
    localparam int unsigned c_RA_W_DEF      = 5;
    localparam int unsigned c_NUM_FWD_DEF   = 3;
    localparam int unsigned c_PAYLOAD_W_DEF = 64;
    localparam int unsigned c_CNT_W_DEF     = 16;

endpackage
`default_nettype wire

// File: rtl/id_operand_fwd_stage_fwd_operand_sel.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_operand_sel
//  Description : Resolves one source operand from the register file or the
//                prioritised forwarding buses (index 0 = youngest, wins).
//  Ports       : i_rs / i_en        source register and read enable
//                i_rf_rdata         register file read data
//                i_fwd_*            flattened forwarding buses
//                o_value            resolved operand value
//                o_hazard           youngest matching producer not ready
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_operand_sel
    import id_operand_fwd_stage_pkg::*;
#(
    parameter int unsigned NUM_FWD = c_NUM_FWD_DEF,
    parameter int unsigned XLEN    = c_XLEN_DEF,
    parameter int unsigned RA_W    = c_RA_W_DEF
) (
    input  logic [RA_W-1:0]         i_rs,
    input  logic                    i_en,
    input  logic [XLEN-1:0]         i_rf_rdata,
    input  logic [NUM_FWD-1:0]      i_fwd_valid,
    input  logic [NUM_FWD*RA_W-1:0] i_fwd_dest,
    input  logic [NUM_FWD-1:0]      i_fwd_data_ok,
    input  logic [NUM_FWD*XLEN-1:0] i_fwd_data,
    output logic [XLEN-1:0]         o_value,
    output logic                    o_hazard
);

    logic w_found;

    // The first match in index order is the youngest producer; once found,
    // older producers of the same register are stale and must be ignored,
    // even if they are ready. A non-zero rs also excludes dest==0 matches.
    always_comb begin
        o_value  = i_rf_rdata;
        o_hazard = 1'b0;
        w_found  = 1'b0;
        if (i_en && (i_rs != '0)) begin
            for (int i = 0; i < NUM_FWD; i++) begin
                if (!w_found && i_fwd_valid[i] &&
                    (i_fwd_dest[i*RA_W +: RA_W] == i_rs)) begin
                    w_found = 1'b1;
                    if (i_fwd_data_ok[i]) begin
                        o_value = i_fwd_data[i*XLEN +: XLEN];
                    end else begin
                        o_hazard = 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/id_operand_fwd_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_operand_fwd_stage
//  Description : Decode-stage operand unit. Holds one instruction slot in a
//                valid/allow_in pipeline stage and resolves both source
//                operands from the register file or the forwarding buses,
//                stalling only while the matching producer's data is not ready.
//  Ports       : in_*      upstream slot handshake, payload, source regs
//                rf_*      register file read port (combinational data)
//                fwd_*     forwarding buses, index 0 highest priority
//                flush     kill the held slot (branch redirect)
//                out_*     downstream handshake, payload, resolved operands
//                hazard    slot valid but stalled on an operand
//                stall_cnt saturating count of operand-stall cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module id_operand_fwd_stage
    import id_operand_fwd_stage_pkg::*;
#(
    parameter int unsigned XLEN      = c_XLEN_DEF,
    parameter int unsigned RA_W      = c_RA_W_DEF,
    parameter int unsigned NUM_FWD   = c_NUM_FWD_DEF,
    parameter int unsigned PAYLOAD_W = c_PAYLOAD_W_DEF,
    parameter int unsigned CNT_W     = c_CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_allow_in,
    input  logic [PAYLOAD_W-1:0]    in_payload,
    input  logic [RA_W-1:0]         in_rs1,
    input  logic [RA_W-1:0]         in_rs2,
    input  logic                    in_rs1_en,
    input  logic                    in_rs2_en,
    output logic [RA_W-1:0]         rf_raddr1,
    output logic [RA_W-1:0]         rf_raddr2,
    input  logic [XLEN-1:0]         rf_rdata1,
    input  logic [XLEN-1:0]         rf_rdata2,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [NUM_FWD*RA_W-1:0] fwd_dest,
    input  logic [NUM_FWD-1:0]      fwd_data_ok,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_allow_in,
    output logic [PAYLOAD_W-1:0]    out_payload,
    output logic [XLEN-1:0]         out_rs1_val,
    output logic [XLEN-1:0]         out_rs2_val,
    output logic                    hazard,
    output logic [CNT_W-1:0]        stall_cnt
);

    logic                 r_valid;
    logic [PAYLOAD_W-1:0] r_payload;
    logic [RA_W-1:0]      r_rs1;
    logic [RA_W-1:0]      r_rs2;
    logic                 r_rs1_en;
    logic                 r_rs2_en;
    logic [CNT_W-1:0]     r_stall_cnt;

    logic                 w_haz1;
    logic                 w_haz2;
    logic                 w_ready_go;

    fwd_operand_sel #(
        .NUM_FWD (NUM_FWD),
        .XLEN    (XLEN),
        .RA_W    (RA_W)
    ) u_sel_rs1 (
        .i_rs          (r_rs1),
        .i_en          (r_rs1_en),
        .i_rf_rdata    (rf_rdata1),
        .i_fwd_valid   (fwd_valid),
        .i_fwd_dest    (fwd_dest),
        .i_fwd_data_ok (fwd_data_ok),
        .i_fwd_data    (fwd_data),
        .o_value       (out_rs1_val),
        .o_hazard      (w_haz1)
    );

    fwd_operand_sel #(
        .NUM_FWD (NUM_FWD),
        .XLEN    (XLEN),
        .RA_W    (RA_W)
    ) u_sel_rs2 (
        .i_rs          (r_rs2),
        .i_en          (r_rs2_en),
        .i_rf_rdata    (rf_rdata2),
        .i_fwd_valid   (fwd_valid),
        .i_fwd_dest    (fwd_dest),
        .i_fwd_data_ok (fwd_data_ok),
        .i_fwd_data    (fwd_data),
        .o_value       (out_rs2_val),
        .o_hazard      (w_haz2)
    );

    assign w_ready_go  = ~(w_haz1 | w_haz2);
    assign hazard      = r_valid & ~w_ready_go;
    assign out_valid   = r_valid & w_ready_go & ~flush;
    assign in_allow_in = ~r_valid | (w_ready_go & out_allow_in);

    assign rf_raddr1   = r_rs1;
    assign rf_raddr2   = r_rs2;
    assign out_payload = r_payload;
    assign stall_cnt   = r_stall_cnt;

    // Flush dominates: it kills the held slot and any slot offered alongside.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_payload <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rs1_en  <= 1'b0;
            r_rs2_en  <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (in_valid && in_allow_in) begin
            r_valid   <= 1'b1;
            r_payload <= in_payload;
            r_rs1     <= in_rs1;
            r_rs2     <= in_rs2;
            r_rs1_en  <= in_rs1_en;
            r_rs2_en  <= in_rs2_en;
        end else if (out_valid && out_allow_in) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (hazard && !flush && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_operand_fwd_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_operand_fwd_stage
//  Description : Self-checking bench for id_operand_fwd_stage: directed
//                scenarios followed by randomized traffic, compared every
//                cycle against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_operand_fwd_stage;

    localparam int XLEN      = 32;
    localparam int RA_W      = 5;
    localparam int NF        = 3;
    localparam int PAYLOAD_W = 64;
    localparam int CNT_W     = 2;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid;
    logic                    in_allow_in;
    logic [PAYLOAD_W-1:0]    in_payload;
    logic [RA_W-1:0]         in_rs1, in_rs2;
    logic                    in_rs1_en, in_rs2_en;
    logic [RA_W-1:0]         rf_raddr1, rf_raddr2;
    logic [XLEN-1:0]         rf_rdata1, rf_rdata2;
    logic [NF-1:0]           fwd_valid;
    logic [NF*RA_W-1:0]      fwd_dest;
    logic [NF-1:0]           fwd_data_ok;
    logic [NF*XLEN-1:0]      fwd_data;
    logic                    flush;
    logic                    out_valid;
    logic                    out_allow_in;
    logic [PAYLOAD_W-1:0]    out_payload;
    logic [XLEN-1:0]         out_rs1_val, out_rs2_val;
    logic                    hazard;
    logic [CNT_W-1:0]        stall_cnt;

    // Stimulus-side forwarding sources and register file contents
    logic                    f_valid [NF];
    logic [RA_W-1:0]         f_dest  [NF];
    logic                    f_ok    [NF];
    logic [XLEN-1:0]         f_data  [NF];
    logic [XLEN-1:0]         rf_mem  [32];

    // Reference model state: the instruction currently held by the stage
    logic                    m_valid;
    logic [PAYLOAD_W-1:0]    m_payload;
    logic [RA_W-1:0]         m_rs1, m_rs2;
    logic                    m_en1, m_en2;
    int                      m_cnt;
    logic                    m_ready;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always_comb begin
        fwd_valid   = '0;
        fwd_dest    = '0;
        fwd_data_ok = '0;
        fwd_data    = '0;
        for (int i = 0; i < NF; i++) begin
            fwd_valid[i]                = f_valid[i];
            fwd_dest[i*RA_W +: RA_W]    = f_dest[i];
            fwd_data_ok[i]              = f_ok[i];
            fwd_data[i*XLEN +: XLEN]    = f_data[i];
        end
    end

    assign rf_rdata1 = rf_mem[rf_raddr1];
    assign rf_rdata2 = rf_mem[rf_raddr2];

    id_operand_fwd_stage #(
        .XLEN      (XLEN),
        .RA_W      (RA_W),
        .NUM_FWD   (NF),
        .PAYLOAD_W (PAYLOAD_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_allow_in  (in_allow_in),
        .in_payload   (in_payload),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_rs1_en    (in_rs1_en),
        .in_rs2_en    (in_rs2_en),
        .rf_raddr1    (rf_raddr1),
        .rf_raddr2    (rf_raddr2),
        .rf_rdata1    (rf_rdata1),
        .rf_rdata2    (rf_rdata2),
        .fwd_valid    (fwd_valid),
        .fwd_dest     (fwd_dest),
        .fwd_data_ok  (fwd_data_ok),
        .fwd_data     (fwd_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_allow_in (out_allow_in),
        .out_payload  (out_payload),
        .out_rs1_val  (out_rs1_val),
        .out_rs2_val  (out_rs2_val),
        .hazard       (hazard),
        .stall_cnt    (stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Operand lookup: the youngest producer writing the register decides;
    // register 0 and unread operands always come from the register file.
    function automatic void resolve(input logic [RA_W-1:0] rs, input logic en,
                                    output logic [XLEN-1:0] v, output logic h);
        v = rf_mem[rs];
        h = 1'b0;
        if (!en || rs == 0) return;
        for (int i = 0; i < NF; i++) begin
            if (f_valid[i] && f_dest[i] == rs) begin
                if (f_ok[i]) v = f_data[i];
                else         h = 1'b1;
                return;
            end
        end
    endfunction

    // Compare all outputs against the model, before the clock edge.
    task automatic settle_check();
        logic [XLEN-1:0] v1, v2;
        logic h1, h2;
        #1;
        resolve(m_rs1, m_en1, v1, h1);
        resolve(m_rs2, m_en2, v2, h2);
        m_ready = !(h1 || h2);
        chk("out_valid",   64'(out_valid),   64'(m_valid && m_ready && !flush));
        chk("in_allow_in", 64'(in_allow_in), 64'(!m_valid || (m_ready && out_allow_in)));
        chk("hazard",      64'(hazard),      64'(m_valid && !m_ready));
        chk("stall_cnt",   64'(stall_cnt),   64'(m_cnt));
        chk("out_payload", out_payload,      m_payload);
        chk("out_rs1_val", 64'(out_rs1_val), 64'(v1));
        chk("out_rs2_val", 64'(out_rs2_val), 64'(v2));
        chk("rf_raddr1",   64'(rf_raddr1),   64'(m_rs1));
        chk("rf_raddr2",   64'(rf_raddr2),   64'(m_rs2));
    endtask

    // Advance the model one cycle and the DUT one clock edge.
    task automatic tick();
        logic accept, leave, stalled;
        accept  = !m_valid || (m_ready && out_allow_in);
        leave   = m_valid && m_ready && !flush && out_allow_in;
        stalled = m_valid && !m_ready;
        if (reset) begin
            m_valid = 0; m_payload = '0; m_rs1 = '0; m_rs2 = '0;
            m_en1 = 0; m_en2 = 0; m_cnt = 0;
        end else begin
            if (stalled && !flush && m_cnt < CNT_MAX) m_cnt++;
            if (flush) m_valid = 0;
            else if (in_valid && accept) begin
                m_valid = 1; m_payload = in_payload;
                m_rs1 = in_rs1; m_rs2 = in_rs2; m_en1 = in_rs1_en; m_en2 = in_rs2_en;
            end else if (leave) m_valid = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        settle_check();
        tick();
    endtask

    task automatic clear_fwd();
        for (int i = 0; i < NF; i++) begin
            f_valid[i] = 0; f_dest[i] = '0; f_ok[i] = 0; f_data[i] = '0;
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = (i == 0) ? '0 : $urandom;
        clear_fwd();
        reset = 1; in_valid = 1; in_payload = 64'hDEAD_BEEF_0000_0001;
        in_rs1 = 5'd3; in_rs2 = 5'd4; in_rs1_en = 1; in_rs2_en = 1;
        flush = 0; out_allow_in = 1;
        m_valid = 0; m_payload = '0; m_rs1 = '0; m_rs2 = '0;
        m_en1 = 0; m_en2 = 0; m_cnt = 0; m_ready = 1;
        @(posedge clk); #1;

        // Reset held 3 cycles with an offered slot
        for (int k = 0; k < 3; k++) begin
            settle_check();
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_allow_in",  64'(in_allow_in), 64'd1);
            chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
            tick();
        end
        reset = 0;

        // Forwarding priority: youngest matching source wins
        in_valid = 1; in_payload = 64'h0000_0000_1000_0040;
        in_rs1 = 5'd5; in_rs1_en = 1; in_rs2 = 5'd0; in_rs2_en = 0;
        out_allow_in = 0;
        step();
        in_valid = 0;
        f_valid[0] = 1; f_dest[0] = 5'd5; f_data[0] = 32'hAAAA; f_ok[0] = 1;
        f_valid[2] = 1; f_dest[2] = 5'd5; f_data[2] = 32'hBBBB; f_ok[2] = 1;
        settle_check();
        chk("prio_fwd0", 64'(out_rs1_val), 64'hAAAA);
        tick();
        f_valid[0] = 0;
        settle_check();
        chk("prio_fwd2", 64'(out_rs1_val), 64'hBBBB);
        out_allow_in = 1;
        tick();
        clear_fwd();

        // Load-use stall on rs2 for two cycles, then release
        in_valid = 1; in_payload = 64'h0000_0000_1000_0044;
        in_rs1 = 5'd1; in_rs1_en = 0; in_rs2 = 5'd7; in_rs2_en = 1;
        step();
        in_valid = 0;
        f_valid[0] = 1; f_dest[0] = 5'd7; f_ok[0] = 0; f_data[0] = 32'h0;
        for (int k = 0; k < 2; k++) begin
            settle_check();
            chk("stall_hazard", 64'(hazard), 64'd1);
            chk("stall_ovalid", 64'(out_valid), 64'd0);
            tick();
        end
        f_ok[0] = 1; f_data[0] = 32'h1234;
        settle_check();
        chk("rel_ovalid", 64'(out_valid), 64'd1);
        chk("rel_rs2",    64'(out_rs2_val), 64'h1234);
        chk("rel_cnt",    64'(stall_cnt), 64'd2);
        tick();
        clear_fwd();

        // x0 never forwards; disabled operand never stalls
        in_valid = 1; in_rs1 = 5'd0; in_rs1_en = 1; in_rs2 = 5'd3; in_rs2_en = 0;
        step();
        in_valid = 0;
        f_valid[0] = 1; f_dest[0] = 5'd0; f_data[0] = 32'hFFFF; f_ok[0] = 1;
        f_valid[1] = 1; f_dest[1] = 5'd3; f_ok[1] = 0;
        settle_check();
        chk("x0_hazard", 64'(hazard), 64'd0);
        chk("x0_val",    64'(out_rs1_val), 64'd0);
        chk("x0_ovalid", 64'(out_valid), 64'd1);
        tick();
        clear_fwd();

        // Flush a stalled slot while a new slot is offered
        reset = 1; step(); reset = 0;
        in_valid = 1; in_rs1 = 5'd4; in_rs1_en = 1; in_rs2_en = 0;
        f_valid[0] = 1; f_dest[0] = 5'd4; f_ok[0] = 0;
        step();
        in_valid = 0;
        step();
        flush = 1; in_valid = 1; in_payload = 64'h0000_0000_2000_0000; in_rs1 = 5'd9;
        step();
        flush = 0; in_valid = 0;
        settle_check();
        chk("flush_ovalid", 64'(out_valid), 64'd0);
        chk("flush_hazard", 64'(hazard), 64'd0);
        chk("flush_cnt",    64'(stall_cnt), 64'd1);
        tick();

        // Counter saturation over 5 stall cycles
        in_valid = 1; in_rs1 = 5'd4;
        step();
        in_valid = 0;
        for (int k = 0; k < 5; k++) step();
        settle_check();
        chk("sat_cnt", 64'(stall_cnt), 64'(CNT_MAX));
        tick();
        clear_fwd();
        step();

        // Back-pressure holds a ready slot
        in_valid = 1; in_payload = 64'h1234_5678_9ABC_DEF0; in_rs1 = 5'd1; in_rs1_en = 1;
        out_allow_in = 0;
        step();
        in_payload = 64'h0BAD_0BAD_0BAD_0BAD;
        for (int k = 0; k < 4; k++) begin
            settle_check();
            chk("bp_ovalid",  64'(out_valid), 64'd1);
            chk("bp_allow",   64'(in_allow_in), 64'd0);
            chk("bp_payload", out_payload, 64'h1234_5678_9ABC_DEF0);
            tick();
        end
        in_valid = 0; out_allow_in = 1;
        step();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            reset        = ($urandom_range(0, 99) == 0);
            flush        = ($urandom_range(0, 15) == 0);
            in_valid     = $urandom_range(0, 1);
            in_payload   = {$urandom, $urandom};
            in_rs1       = 5'($urandom_range(0, 7));
            in_rs2       = 5'($urandom_range(0, 7));
            in_rs1_en    = ($urandom_range(0, 3) != 0);
            in_rs2_en    = ($urandom_range(0, 3) != 0);
            out_allow_in = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NF; i++) begin
                f_valid[i] = $urandom_range(0, 1);
                f_dest[i]  = 5'($urandom_range(0, 7));
                f_ok[i]    = ($urandom_range(0, 9) < 7);
                f_data[i]  = $urandom;
            end
            if ($urandom_range(0, 7) == 0) rf_mem[$urandom_range(1, 7)] = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
